freq_sweep_ctrl: RTL

Frequency-word sequencer that sits directly upstream of the 14-bit DDS core and drives its 12-bit `FRQ_W` input. It sweeps the frequency word between programmed limits with a programmable dwell per step. It supports fixed, single-sweep, repeating-sweep and triangle (up/down) modes, so the DDS output can be swept without software pacing.

---
 rtl/freq_sweep_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/freq_sweep_ctrl.sv
// Frequency-word sequencer feeding the DDS FRQ_W input.
// Fixed, single, repeating and triangle sweeps with a per-word dwell.
module freq_sweep_ctrl #(
  parameter int W       = 12,
  parameter int DWELL_W = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         mode,
  input  logic               start,
  input  logic               stop,
  input  logic [W-1:0]       f_start,
  input  logic [W-1:0]       f_stop,
  input  logic [W-1:0]       f_step,
  input  logic [DWELL_W-1:0] dwell,
  output logic [W-1:0]       frq_w,
  output logic               busy,
  output logic               dir,
  output logic               sweep_done,
  output logic               cfg_err
);

  // Stepping happens in the last HOLD cycle, so no separate step state.
  typedef enum logic [0:0] {
    IDLE,
    HOLD
  } state_t;

  state_t state_q, state_d;

  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] d_q;
  logic [1:0]         mode_q;
  logic [W-1:0]       fs_q, fe_q, st_q;

  logic [W-1:0] frq_d;
  logic         busy_d, dir_d, done_d, err_d;
  logic         latch;

  logic [W:0]   up_sum, dn_dif;
  logic [W-1:0] up_nxt, dn_nxt;
  logic         cfg_bad, last;

  assign up_sum = {1'b0, frq_w} + {1'b0, st_q};
  assign dn_dif = {1'b0, frq_w} - {1'b0, st_q};

  assign up_nxt = (up_sum >= {1'b0, fe_q}) ? fe_q : up_sum[W-1:0];
  assign dn_nxt = (dn_dif[W] || dn_dif[W-1:0] <= fs_q)
                ? fs_q : dn_dif[W-1:0];

  assign cfg_bad = (mode != 2'b00) &&
                   ((f_step == '0) || (f_stop <= f_start));

  assign last = (cnt_q == d_q - DWELL_W'(1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    frq_d   = frq_w;
    busy_d  = busy;
    dir_d   = dir;
    done_d  = 1'b0;
    err_d   = 1'b0;
    latch   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          latch = 1'b1;
          frq_d = f_start;
          if (mode == 2'b00 || cfg_bad) begin
            err_d = cfg_bad;
          end else begin
            state_d = HOLD;
            busy_d  = 1'b1;
            dir_d   = 1'b0;
            cnt_d   = '0;
          end
        end
      end
      HOLD: begin
        if (stop) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          dir_d   = 1'b0;
          cnt_d   = '0;
        end else if (!last) begin
          cnt_d = cnt_q + DWELL_W'(1);
        end else begin
          cnt_d = '0;
          if (!dir) begin
            if (frq_w == fe_q) begin
              unique case (mode_q)
                2'b10: begin
                  frq_d  = fs_q;
                  done_d = 1'b1;
                end
                2'b11: begin
                  dir_d = 1'b1;
                  frq_d = dn_nxt;
                end
                default: begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                end
              endcase
            end else begin
              frq_d = up_nxt;
            end
          end else if (frq_w == fs_q) begin
            dir_d  = 1'b0;
            done_d = 1'b1;
            frq_d  = up_nxt;
          end else begin
            frq_d = dn_nxt;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      frq_w      <= '0;
      busy       <= 1'b0;
      dir        <= 1'b0;
      sweep_done <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      frq_w      <= frq_d;
      busy       <= busy_d;
      dir        <= dir_d;
      sweep_done <= done_d;
      cfg_err    <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_q    <= '0;
      mode_q <= 2'b00;
      fs_q   <= '0;
      fe_q   <= '0;
      st_q   <= '0;
    end else if (latch) begin
      d_q    <= (dwell == '0) ? DWELL_W'(1) : dwell;
      mode_q <= mode;
      fs_q   <= f_start;
      fe_q   <= f_stop;
      st_q   <= f_step;
    end
  end

endmodule
